// File: rtl/fadd32_far_path_align_pipe.sv
// fadd32 far-path operand alignment: swap by magnitude, then right-shift the small significand with sticky.
// Optional flush input is enabled by defining FADD32_ALIGN_FLUSH_EN.
module fadd32_far_path_align_pipe (
    input  logic        clk,
    input  logic        rst,
`ifdef FADD32_ALIGN_FLUSH_EN
    input  logic        flush_i,
`endif
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        sub_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        sign_o,
    output logic        do_sub_o,
    output logic [7:0]  exp_large_o,
    output logic [7:0]  exp_diff_o,
    output logic [23:0] sig_large_o,
    output logic [47:0] sig_small_aligned_o,
    output logic        sticky_o,
    output logic        nan_inf_o
);
    localparam int unsigned SIG_W = 24;
    localparam int unsigned WIN_W = 2 * SIG_W;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned SH_W  = 6;

    logic flush_c;
`ifdef FADD32_ALIGN_FLUSH_EN
    assign flush_c = flush_i;
`else
    assign flush_c = 1'b0;
`endif

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic             s1_do_sub_q, s1_do_sub_d;
    logic [EXP_W-1:0] s1_exp_large_q, s1_exp_large_d;
    logic [EXP_W-1:0] s1_exp_diff_q, s1_exp_diff_d;
    logic             s1_exp_zero_q, s1_exp_zero_d;
    logic [SIG_W-1:0] s1_sig_large_q, s1_sig_large_d;
    logic [SIG_W-1:0] s1_sig_small_q, s1_sig_small_d;

    // Stage 2 (output) registers
    logic             s2_valid_q, s2_valid_d;
    logic             s2_sign_q, s2_sign_d;
    logic             s2_do_sub_q, s2_do_sub_d;
    logic [EXP_W-1:0] s2_exp_large_q, s2_exp_large_d;
    logic [EXP_W-1:0] s2_exp_diff_q, s2_exp_diff_d;
    logic [SIG_W-1:0] s2_sig_large_q, s2_sig_large_d;
    logic [WIN_W-1:0] s2_aligned_q, s2_aligned_d;
    logic             s2_sticky_q, s2_sticky_d;
    logic             s2_nan_inf_q, s2_nan_inf_d;

    logic s2_adv_c, s1_adv_c;
    assign s2_adv_c   = !s2_valid_q || out_ready_i;
    assign s1_adv_c   = !s1_valid_q || s2_adv_c;
    assign in_ready_o = s1_adv_c && !flush_c;

    // Stage 1 datapath: order operands by magnitude; equal magnitudes keep A first
    logic             swap_c;
    logic [31:0]      op_l_c, op_s_c;
    logic [EXP_W-1:0] exp_l_c, exp_s_c;
    assign swap_c  = opb_i[30:0] > opa_i[30:0];
    assign op_l_c  = swap_c ? opb_i : opa_i;
    assign op_s_c  = swap_c ? opa_i : opb_i;
    assign exp_l_c = op_l_c[30:23];
    assign exp_s_c = op_s_c[30:23];

    // Stage 2 datapath: a 96-bit shift keeps both the window and the bits pushed out of it
    logic [EXP_W-1:0]     rsh_raw_c;
    logic [SH_W-1:0]      rsh_c;
    logic [2*WIN_W-1:0]   shifted_c;
    assign rsh_raw_c = s1_exp_diff_q - EXP_W'(s1_exp_zero_q);
    assign rsh_c     = (rsh_raw_c > EXP_W'(WIN_W)) ? SH_W'(WIN_W) : rsh_raw_c[SH_W-1:0];
    assign shifted_c = {s1_sig_small_q, (2*WIN_W-SIG_W)'(0)} >> rsh_c;

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_sign_d      = s1_sign_q;
        s1_do_sub_d    = s1_do_sub_q;
        s1_exp_large_d = s1_exp_large_q;
        s1_exp_diff_d  = s1_exp_diff_q;
        s1_exp_zero_d  = s1_exp_zero_q;
        s1_sig_large_d = s1_sig_large_q;
        s1_sig_small_d = s1_sig_small_q;
        s2_valid_d     = s2_valid_q;
        s2_sign_d      = s2_sign_q;
        s2_do_sub_d    = s2_do_sub_q;
        s2_exp_large_d = s2_exp_large_q;
        s2_exp_diff_d  = s2_exp_diff_q;
        s2_sig_large_d = s2_sig_large_q;
        s2_aligned_d   = s2_aligned_q;
        s2_sticky_d    = s2_sticky_q;
        s2_nan_inf_d   = s2_nan_inf_q;

        if (s1_adv_c) begin
            s1_valid_d = in_valid_i && in_ready_o;
        end
        if (in_valid_i && in_ready_o) begin
            s1_sign_d      = swap_c ? (opb_i[31] ^ sub_i) : opa_i[31];
            s1_do_sub_d    = opa_i[31] ^ opb_i[31] ^ sub_i;
            s1_exp_large_d = exp_l_c;
            s1_exp_diff_d  = exp_l_c - exp_s_c;
            s1_exp_zero_d  = (exp_s_c == '0) && (exp_l_c != '0);
            s1_sig_large_d = {exp_l_c != '0, op_l_c[22:0]};
            s1_sig_small_d = {exp_s_c != '0, op_s_c[22:0]};
        end

        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q && !flush_c) begin
                s2_sign_d      = s1_sign_q;
                s2_do_sub_d    = s1_do_sub_q;
                s2_exp_large_d = s1_exp_large_q;
                s2_exp_diff_d  = s1_exp_diff_q;
                s2_sig_large_d = s1_sig_large_q;
                s2_aligned_d   = shifted_c[2*WIN_W-1:WIN_W];
                s2_sticky_d    = |shifted_c[WIN_W-1:0];
                s2_nan_inf_d   = (s1_exp_large_q == 8'hFF);
            end
        end

        if (flush_c) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_do_sub_q    <= 1'b0;
            s1_exp_large_q <= '0;
            s1_exp_diff_q  <= '0;
            s1_exp_zero_q  <= 1'b0;
            s1_sig_large_q <= '0;
            s1_sig_small_q <= '0;
            s2_valid_q     <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_do_sub_q    <= 1'b0;
            s2_exp_large_q <= '0;
            s2_exp_diff_q  <= '0;
            s2_sig_large_q <= '0;
            s2_aligned_q   <= '0;
            s2_sticky_q    <= 1'b0;
            s2_nan_inf_q   <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sign_q      <= s1_sign_d;
            s1_do_sub_q    <= s1_do_sub_d;
            s1_exp_large_q <= s1_exp_large_d;
            s1_exp_diff_q  <= s1_exp_diff_d;
            s1_exp_zero_q  <= s1_exp_zero_d;
            s1_sig_large_q <= s1_sig_large_d;
            s1_sig_small_q <= s1_sig_small_d;
            s2_valid_q     <= s2_valid_d;
            s2_sign_q      <= s2_sign_d;
            s2_do_sub_q    <= s2_do_sub_d;
            s2_exp_large_q <= s2_exp_large_d;
            s2_exp_diff_q  <= s2_exp_diff_d;
            s2_sig_large_q <= s2_sig_large_d;
            s2_aligned_q   <= s2_aligned_d;
            s2_sticky_q    <= s2_sticky_d;
            s2_nan_inf_q   <= s2_nan_inf_d;
        end
    end

    assign out_valid_o         = s2_valid_q;
    assign sign_o              = s2_sign_q;
    assign do_sub_o            = s2_do_sub_q;
    assign exp_large_o         = s2_exp_large_q;
    assign exp_diff_o          = s2_exp_diff_q;
    assign sig_large_o         = s2_sig_large_q;
    assign sig_small_aligned_o = s2_aligned_q;
    assign sticky_o            = s2_sticky_q;
    assign nan_inf_o           = s2_nan_inf_q;
endmodule

// File: tb/tb_fadd32_far_path_align_pipe.sv
// Bench for fadd32_far_path_align_pipe: vector table, modelled random traffic, stall and reset sequences.
module tb_fadd32_far_path_align_pipe;
    typedef struct packed {
        logic        sign;
        logic        do_sub;
        logic [7:0]  exp_large;
        logic [7:0]  exp_diff;
        logic [23:0] sig_large;
        logic [47:0] aligned;
        logic        sticky;
        logic        nan_inf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i, in_ready_o, sub_i;
    logic [31:0] opa_i, opb_i;
    logic        out_valid_o, out_ready_i;
    logic        sign_o, do_sub_o, sticky_o, nan_inf_o;
    logic [7:0]  exp_large_o, exp_diff_o;
    logic [23:0] sig_large_o;
    logic [47:0] sig_small_aligned_o;

    int total = 0;
    int bad   = 0;
    res_t exp_q[$];
    bit   rand_bp = 1'b0;

    always #5 clk = ~clk;

    fadd32_far_path_align_pipe dut (
        .clk                 (clk),
        .rst                 (rst),
`ifdef FADD32_ALIGN_FLUSH_EN
        .flush_i             (flush_i),
`endif
        .in_valid_i          (in_valid_i),
        .in_ready_o          (in_ready_o),
        .opa_i               (opa_i),
        .opb_i               (opb_i),
        .sub_i               (sub_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .sign_o              (sign_o),
        .do_sub_o            (do_sub_o),
        .exp_large_o         (exp_large_o),
        .exp_diff_o          (exp_diff_o),
        .sig_large_o         (sig_large_o),
        .sig_small_aligned_o (sig_small_aligned_o),
        .sticky_o            (sticky_o),
        .nan_inf_o           (nan_inf_o)
    );

    function automatic res_t dut_res();
        return '{sign_o, do_sub_o, exp_large_o, exp_diff_o, sig_large_o,
                 sig_small_aligned_o, sticky_o, nan_inf_o};
    endfunction

    // Bit-by-bit reference: bits below the shift amount go to sticky, the rest move down
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t        r;
        logic        sw;
        logic [31:0] l, sm;
        logic [47:0] ext;
        int          el, es, sh;
        sw  = (b[30:0] > a[30:0]);
        l   = sw ? b : a;
        sm  = sw ? a : b;
        el  = int'(l[30:23]);
        es  = int'(sm[30:23]);
        r.sign      = sw ? (b[31] ^ s) : a[31];
        r.do_sub    = a[31] ^ b[31] ^ s;
        r.exp_large = l[30:23];
        r.exp_diff  = 8'(el - es);
        r.sig_large = {(el != 0), l[22:0]};
        r.nan_inf   = (el == 255);
        ext = {(es != 0), sm[22:0], 24'h0};
        sh  = el - es - ((es == 0 && el != 0) ? 1 : 0);
        if (sh > 48) sh = 48;
        r.aligned = '0;
        r.sticky  = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (i < sh) r.sticky = r.sticky | ext[i];
            else        r.aligned[i - sh] = ext[i];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard side: sample just before each rising edge
    always @(negedge clk) begin
        res_t e;
        #3;
        if (!rst && out_valid_o && out_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got %h with no entry pending", dut_res());
            end else begin
                e = exp_q.pop_front();
                if (dut_res() !== e) begin
                    bad++;
                    $display("FAIL result: got %h expected %h", dut_res(), e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input res_t e);
        int waitc = 0;
        @(negedge clk);
        in_valid_i = 1'b1; opa_i = a; opb_i = b; sub_i = s;
        if (rand_bp) out_ready_i = 1'($urandom_range(0, 1));
        #1;
        while (!in_ready_o && waitc < 50) begin
            @(negedge clk);
            if (rand_bp) out_ready_i = 1'($urandom_range(0, 1));
            #1;
            waitc++;
        end
        if (!in_ready_o) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready_o=%b expected 1", in_ready_o);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
        end
    endtask

    vec_t vt[9];
    res_t x1, x2, x3, snap;

    initial begin
        vt[0] = '{32'h3F800000, 32'h3F000000, 1'b0, '{1'b0, 1'b0, 8'h7F, 8'h01, 24'h800000, 48'h400000_000000, 1'b0, 1'b0}};
        vt[1] = '{32'h3F000000, 32'hBF800000, 1'b0, '{1'b1, 1'b1, 8'h7F, 8'h01, 24'h800000, 48'h400000_000000, 1'b0, 1'b0}};
        vt[2] = '{32'h3F800000, 32'h00000001, 1'b0, '{1'b0, 1'b0, 8'h7F, 8'h7F, 24'h800000, 48'h000000_000000, 1'b1, 1'b0}};
        vt[3] = '{32'h4C000000, 32'h3F800001, 1'b0, '{1'b0, 1'b0, 8'h98, 8'h19, 24'h800000, 48'h000000_400000, 1'b1, 1'b0}};
        vt[4] = '{32'h4B800000, 32'h3F800001, 1'b0, '{1'b0, 1'b0, 8'h97, 8'h18, 24'h800000, 48'h000000_800001, 1'b0, 1'b0}};
        vt[5] = '{32'h3F800000, 32'hBF800000, 1'b1, '{1'b0, 1'b0, 8'h7F, 8'h00, 24'h800000, 48'h800000_000000, 1'b0, 1'b0}};
        vt[6] = '{32'h00000003, 32'h00000001, 1'b0, '{1'b0, 1'b0, 8'h00, 8'h00, 24'h000003, 48'h000001_000000, 1'b0, 1'b0}};
        vt[7] = '{32'h7F800000, 32'h3F800000, 1'b0, '{1'b0, 1'b0, 8'hFF, 8'h80, 24'h800000, 48'h000000_000000, 1'b1, 1'b1}};
        vt[8] = '{32'h40000000, 32'h40400000, 1'b1, '{1'b1, 1'b1, 8'h80, 8'h00, 24'hC00000, 48'h800000_000000, 1'b0, 1'b0}};

        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        opa_i = '0; opb_i = '0; sub_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 96'(out_valid_o), 96'(1'b0));
        chk("reset_in_ready", 96'(in_ready_o), 96'(1'b1));
        chk("reset_data", 96'(dut_res()), 96'(0));

        // Directed vectors back-to-back
        for (int i = 0; i < 9; i++) send(vt[i].a, vt[i].b, vt[i].sub, vt[i].exp);
        idle();
        drain();

        // Random operands with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom();
            b = $urandom();
            if (i % 2 == 0) b[30:23] = 8'(int'(a[30:23]) - int'($urandom_range(0, 30)));
            if (i % 7 == 0) b[30:23] = 8'h00;
            s = 1'($urandom_range(0, 1));
            send(a, b, s, model(a, b, s));
        end
        rand_bp = 1'b0;
        idle();
        out_ready_i = 1'b1;
        drain();

        // Stall: two accepted, third refused, output held stable
        x1 = model(32'h41200000, 32'h3DCCCCCD, 1'b0);
        x2 = model(32'hC2C80000, 32'h42C80001, 1'b1);
        x3 = model(32'h00400000, 32'h00000005, 1'b0);
        @(negedge clk);
        out_ready_i = 1'b0;
        send(32'h41200000, 32'h3DCCCCCD, 1'b0, x1);
        send(32'hC2C80000, 32'h42C80001, 1'b1, x2);
        @(negedge clk);
        opa_i = 32'h00400000; opb_i = 32'h00000005; sub_i = 1'b0; in_valid_i = 1'b1;
        #1;
        chk("stall_in_ready", 96'(in_ready_o), 96'(1'b0));
        snap = dut_res();
        chk("stall_first_out", 96'(snap), 96'(x1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stall_valid_held", 96'(out_valid_o), 96'(1'b1));
            chk("stall_data_held", 96'(dut_res()), 96'(snap));
            chk("stall_in_ready_low", 96'(in_ready_o), 96'(1'b0));
        end
        @(negedge clk);
        out_ready_i = 1'b1;
        #1;
        chk("release_in_ready", 96'(in_ready_o), 96'(1'b1));
        exp_q.push_back(x3);
        #2;
        chk("b2b_valid0", 96'(out_valid_o), 96'(1'b1));
        @(negedge clk);
        in_valid_i = 1'b0;
        #3;
        chk("b2b_valid1", 96'(out_valid_o), 96'(1'b1));
        @(negedge clk);
        #3;
        chk("b2b_valid2", 96'(out_valid_o), 96'(1'b1));
        idle();
        drain();

        // Reset with two entries in flight
        @(negedge clk);
        out_ready_i = 1'b0;
        send(vt[0].a, vt[0].b, vt[0].sub, vt[0].exp);
        send(vt[1].a, vt[1].b, vt[1].sub, vt[1].exp);
        @(negedge clk);
        in_valid_i = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_flight_valid", 96'(out_valid_o), 96'(1'b0));
        chk("rst_flight_in_ready", 96'(in_ready_o), 96'(1'b1));
        chk("rst_flight_data", 96'(exp_large_o), 96'(8'h00));
        @(negedge clk);
        rst = 1'b0;
        out_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_stale", 96'(out_valid_o), 96'(1'b0));

`ifdef FADD32_ALIGN_FLUSH_EN
        // Flush with two entries in flight
        @(negedge clk);
        out_ready_i = 1'b0;
        send(vt[2].a, vt[2].b, vt[2].sub, vt[2].exp);
        send(vt[3].a, vt[3].b, vt[3].sub, vt[3].exp);
        @(negedge clk);
        in_valid_i = 1'b0;
        flush_i = 1'b1;
        exp_q.delete();
        #1;
        chk("flush_in_ready", 96'(in_ready_o), 96'(1'b0));
        @(posedge clk);
        #1;
        chk("flush_valid", 96'(out_valid_o), 96'(1'b0));
        chk("flush_data_kept", 96'(exp_large_o), 96'(vt[2].exp.exp_large));
        @(negedge clk);
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_no_stale", 96'(out_valid_o), 96'(1'b0));
`endif

        // Pipeline still usable afterwards
        send(vt[6].a, vt[6].b, vt[6].sub, vt[6].exp);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
